// File: rtl/ow_bus_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ow_pkg                                                      |
// | Brief  : Shared constants for the 1-Wire bus arbiter: engine command |
// |          codes, one-hot arbiter state encoding, 1-Wire ROM/function  |
// |          bytes used by the requesting controllers.                   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package ow_pkg;

   // Engine command codes (also the requester command codes)
   localparam logic [1:0] OW_CMD_NONE  = 2'd0;
   localparam logic [1:0] OW_CMD_INIT  = 2'd1;
   localparam logic [1:0] OW_CMD_WRITE = 2'd2;
   localparam logic [1:0] OW_CMD_READ  = 2'd3;

   // Arbiter state encoding, one-hot
   localparam int         ST_W     = 3;
   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_OWNED = 3'b010;
   localparam logic [2:0] ST_BUSY  = 3'b100;

   // 1-Wire ROM and function command bytes
   localparam logic [7:0] OW_ROM_SKIP          = 8'hCC;
   localparam logic [7:0] OW_ROM_MATCH         = 8'h55;
   localparam logic [7:0] OW_FN_CONVERT        = 8'h44;
   localparam logic [7:0] OW_FN_READ_SCRATCH   = 8'hBE;
   localparam logic [7:0] OW_FN_WRITE_SCRATCH  = 8'h4E;

   // A command code the engine can execute
   function automatic logic cmd_is_legal(input logic [1:0] code);
      return code != OW_CMD_NONE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ow_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ow_bus_arbiter_if                                           |
// | Brief  : Requester handshake and 1-Wire engine signals of the bus    |
// |          arbiter. slave = arbiter side, master = requesters+engine.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface ow_bus_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   cmd_valid;
   logic [2*NUM_REQ-1:0] cmd;
   logic [8*NUM_REQ-1:0] cmd_data;
   logic                 cmd_done;
   logic                 cmd_err;
   logic                 presence;
   logic [15:0]          rd_data;
   logic [1:0]           ow_cmd;
   logic [7:0]           ow_data;
   logic                 ow_end_init;
   logic [2:0]           ow_cmd_ok;
   logic [15:0]          ow_rec_data;

   modport slave (
      input  req, cmd_valid, cmd, cmd_data, ow_end_init, ow_cmd_ok, ow_rec_data,
      output gnt, cmd_done, cmd_err, presence, rd_data, ow_cmd, ow_data
   );

   modport master (
      output req, cmd_valid, cmd, cmd_data, ow_end_init, ow_cmd_ok, ow_rec_data,
      input  gnt, cmd_done, cmd_err, presence, rd_data, ow_cmd, ow_data
   );
endinterface
`default_nettype wire

// File: rtl/ow_bus_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ow_rr_pick                                                  |
// | Brief  : Combinational round-robin selector. Searches req starting   |
// |          one past rr_ptr with wrap; returns one-hot, index and any.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module ow_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0]   win_idx,
   output logic               any
);

   // First set request after the last owner, wrapping around
   always_comb begin
      logic [IDX_W-1:0] cand;
      cand       = '0;
      win_onehot = '0;
      win_idx    = '0;
      any        = 1'b0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (!any && req[cand]) begin
            any              = 1'b1;
            win_idx          = cand;
            win_onehot[cand] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ow_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ow_bus_arbiter                                              |
// | Brief  : Round-robin owner of one 1-Wire engine shared by NUM_REQ    |
// |          controllers. The owner keeps the bus for a whole multi-     |
// |          command transaction; each command is forwarded to the       |
// |          engine and completion/status/read data returned.            |
// |          Optional: OW_ARB_WDT_EN adds a per-command watchdog of      |
// |          TIMEOUT_CYC cycles that ends a stuck command with cmd_err.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module ow_bus_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   ow_bus_arbiter_if.slave  bus
);
   import ow_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [ST_W-1:0]    state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [1:0]         pend_q, pend_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [1:0]         ow_cmd_q, ow_cmd_d;
   logic [7:0]         ow_data_q, ow_data_d;
   logic               cmd_done_q, cmd_done_d;
   logic               cmd_err_q, cmd_err_d;
   logic               presence_q, presence_d;
   logic [15:0]        rd_data_q, rd_data_d;

   logic [NUM_REQ-1:0] w_win_onehot;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_any;
   logic [1:0]         w_cmd_arr  [NUM_REQ];
   logic [7:0]         w_data_arr [NUM_REQ];
   logic               w_own_req;
   logic               w_own_valid;
   logic [1:0]         w_own_cmd;
   logic [7:0]         w_own_data;
   logic               w_complete;
   logic               w_timeout;
   logic               w_finish;

   ow_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (bus.req),
      .rr_ptr     (rr_ptr_q),
      .win_onehot (w_win_onehot),
      .win_idx    (w_win_idx),
      .any        (w_win_any)
   );

   // Split the packed per-requester command fields
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_cmd_arr[g]  = bus.cmd[2*g +: 2];
      assign w_data_arr[g] = bus.cmd_data[8*g +: 8];
   end

   assign w_own_req   = bus.req[owner_q];
   assign w_own_valid = bus.cmd_valid[owner_q];
   assign w_own_cmd   = w_cmd_arr[owner_q];
   assign w_own_data  = w_data_arr[owner_q];

   // Engine completion qualifier for the command in flight
   always_comb begin
      w_complete = 1'b0;
      if (state_q == ST_BUSY) begin
         case (pend_q)
            OW_CMD_INIT:  w_complete = bus.ow_end_init;
            OW_CMD_WRITE: w_complete = bus.ow_cmd_ok[1];
            OW_CMD_READ:  w_complete = bus.ow_cmd_ok[2];
            default:      w_complete = 1'b0;
         endcase
      end
   end

`ifdef OW_ARB_WDT_EN
   localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);

   logic [WDT_W-1:0] wdt_q, wdt_d;

   // Counter runs only in BUSY; it is zero on every entry to BUSY
   always_comb begin
      wdt_d = (state_q == ST_BUSY) ? wdt_q + WDT_W'(1) : '0;
   end

   // Watchdog counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wdt_q <= '0;
      else     wdt_q <= wdt_d;
   end

   // A completion on the limit cycle wins over the timeout
   assign w_timeout = (state_q == ST_BUSY) && !w_complete &&
                      (wdt_q == WDT_W'(TIMEOUT_CYC - 1));
`else
   logic [31:0] w_unused_timeout;

   assign w_unused_timeout = 32'(TIMEOUT_CYC);
   assign w_timeout        = 1'b0;
`endif

   assign w_finish = w_complete || w_timeout;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= '0;
         rr_ptr_q   <= IDX_W'(NUM_REQ - 1);
         pend_q     <= OW_CMD_NONE;
         gnt_q      <= '0;
         ow_cmd_q   <= OW_CMD_NONE;
         ow_data_q  <= '0;
         cmd_done_q <= 1'b0;
         cmd_err_q  <= 1'b0;
         presence_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         pend_q     <= pend_d;
         gnt_q      <= gnt_d;
         ow_cmd_q   <= ow_cmd_d;
         ow_data_q  <= ow_data_d;
         cmd_done_q <= cmd_done_d;
         cmd_err_q  <= cmd_err_d;
         presence_q <= presence_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Next state: grant, command dispatch, release (release beats a strobe)
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      pend_d   = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (w_win_any) begin
               state_d = ST_OWNED;
               owner_d = w_win_idx;
            end
         end
         ST_OWNED: begin
            if (!w_own_req) begin
               state_d  = ST_IDLE;
               rr_ptr_d = owner_q;
            end else if (w_own_valid && cmd_is_legal(w_own_cmd)) begin
               state_d = ST_BUSY;
               pend_d  = w_own_cmd;
            end
         end
         ST_BUSY: begin
            if (w_finish) begin
               if (w_own_req) begin
                  state_d = ST_OWNED;
               end else begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = owner_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registered outputs: grant, engine strobe, completion status
   always_comb begin
      gnt_d      = gnt_q;
      ow_cmd_d   = OW_CMD_NONE;
      ow_data_d  = ow_data_q;
      cmd_done_d = 1'b0;
      cmd_err_d  = 1'b0;
      presence_d = presence_q;
      rd_data_d  = rd_data_q;
      case (state_q)
         ST_IDLE: begin
            if (w_win_any) gnt_d = w_win_onehot;
         end
         ST_OWNED: begin
            if (!w_own_req) begin
               gnt_d = '0;
            end else if (w_own_valid) begin
               if (cmd_is_legal(w_own_cmd)) begin
                  ow_cmd_d  = w_own_cmd;
                  ow_data_d = w_own_data;
               end else begin
                  cmd_done_d = 1'b1;
                  cmd_err_d  = 1'b1;
               end
            end
         end
         ST_BUSY: begin
            if (w_complete) begin
               cmd_done_d = 1'b1;
               if (pend_q == OW_CMD_INIT) presence_d = bus.ow_cmd_ok[0];
               if (pend_q == OW_CMD_READ) rd_data_d  = bus.ow_rec_data;
            end else if (w_timeout) begin
               cmd_done_d = 1'b1;
               cmd_err_d  = 1'b1;
            end
            if (w_finish && !w_own_req) gnt_d = '0;
         end
         default: gnt_d = '0;
      endcase
   end

   assign bus.gnt      = gnt_q;
   assign bus.ow_cmd   = ow_cmd_q;
   assign bus.ow_data  = ow_data_q;
   assign bus.cmd_done = cmd_done_q;
   assign bus.cmd_err  = cmd_err_q;
   assign bus.presence = presence_q;
   assign bus.rd_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ow_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_ow_bus_arbiter                                           |
// | Brief  : Self-checking bench for ow_bus_arbiter. The bench plays     |
// |          the requesters and the 1-Wire engine; expected grants and   |
// |          results come from a round-robin/scoreboard model.           |
// |          Define OW_ARB_WDT_EN to also exercise the watchdog.         |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_ow_bus_arbiter;
   import ow_pkg::*;

   localparam int N  = 4;
   localparam int CW = 2 * N;
   localparam int DW = 8 * N;
`ifdef OW_ARB_WDT_EN
   localparam int TO = 100;
`else
   localparam int TO = 1000;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ow_bus_arbiter_if #(.NUM_REQ(N)) bus ();

   ow_bus_arbiter #(
      .NUM_REQ     (N),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_pass  = 0;
   int          n_total = 0;
   int          n_fail  = 0;
   int          last_m;
   logic        pres_m;
   logic [15:0] rd_m;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: first requester after the last owner, with wrap
   function automatic int pick(input logic [N-1:0] r, input int last);
      logic [N-1:0] s;
      for (int off = 1; off <= N; off++) begin
         s = r >> ((last + off) % N);
         if (s[0]) return (last + off) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] bit_of(input int k);
      return N'(1) << k;
   endfunction

   task automatic set_field(input int k, input logic [1:0] code, input logic [7:0] data);
      bus.cmd      = (bus.cmd & ~(CW'(2'b11) << (2*k))) | (CW'(code) << (2*k));
      bus.cmd_data = (bus.cmd_data & ~(DW'(8'hFF) << (8*k))) | (DW'(data) << (8*k));
   endtask

   task automatic engine_idle();
      bus.ow_end_init = 1'b0;
      bus.ow_cmd_ok   = 3'b000;
      bus.ow_rec_data = '0;
   endtask

   task automatic do_reset();
      bus.req       = '0;
      bus.cmd_valid = '0;
      bus.cmd       = '0;
      bus.cmd_data  = '0;
      engine_idle();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_gnt",      32'(bus.gnt),      32'd0);
      chk("rst_ow_cmd",   32'(bus.ow_cmd),   32'd0);
      chk("rst_ow_data",  32'(bus.ow_data),  32'd0);
      chk("rst_cmd_done", 32'(bus.cmd_done), 32'd0);
      chk("rst_cmd_err",  32'(bus.cmd_err),  32'd0);
      chk("rst_presence", 32'(bus.presence), 32'd0);
      chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
      rst    = 1'b0;
      last_m = N - 1;
      pres_m = 1'b0;
      rd_m   = '0;
   endtask

   // Owner k issues one command; the bench answers as the engine after dly cycles
   task automatic do_cmd(input int k, input logic [1:0] code, input logic [7:0] data,
                         input int dly, input logic pres, input logic [15:0] rec);
      bus.cmd      = CW'($urandom);
      bus.cmd_data = DW'($urandom);
      set_field(k, code, data);
      bus.cmd_valid = (N'($urandom) & ~bit_of(k)) | bit_of(k);
      tick();
      bus.cmd_valid = '0;
      if (code == OW_CMD_NONE) begin
         chk("illegal_done", 32'(bus.cmd_done), 32'd1);
         chk("illegal_err",  32'(bus.cmd_err),  32'd1);
         chk("illegal_nocmd", 32'(bus.ow_cmd),  32'd0);
         tick();
         chk("illegal_done_pulse", 32'(bus.cmd_done), 32'd0);
         return;
      end
      chk("ow_cmd_issue", 32'(bus.ow_cmd),  32'(code));
      chk("ow_data",      32'(bus.ow_data), 32'(data));
      for (int c = 0; c < dly; c++) begin
         bus.ow_rec_data  = 16'($urandom);
         bus.ow_end_init  = (code != OW_CMD_INIT)  && ($urandom_range(0, 1) == 1);
         bus.ow_cmd_ok[0] = ($urandom_range(0, 1) == 1);
         bus.ow_cmd_ok[1] = (code != OW_CMD_WRITE) && ($urandom_range(0, 1) == 1);
         bus.ow_cmd_ok[2] = (code != OW_CMD_READ)  && ($urandom_range(0, 1) == 1);
         set_field(k, 2'($urandom_range(1, 3)), 8'($urandom));
         bus.cmd_valid = N'($urandom_range(0, 1)) << k;
         tick();
         bus.cmd_valid = '0;
         chk("busy_no_cmd",  32'(bus.ow_cmd),   32'd0);
         chk("busy_no_done", 32'(bus.cmd_done), 32'd0);
         chk("busy_ow_data", 32'(bus.ow_data),  32'(data));
      end
      engine_idle();
      bus.ow_rec_data = rec;
      case (code)
         OW_CMD_INIT:  begin bus.ow_end_init = 1'b1; bus.ow_cmd_ok[0] = pres; end
         OW_CMD_WRITE: bus.ow_cmd_ok[1] = 1'b1;
         default:      bus.ow_cmd_ok[2] = 1'b1;
      endcase
      tick();
      engine_idle();
      if (code == OW_CMD_READ) rd_m = rec;
      chk("done",     32'(bus.cmd_done), 32'd1);
      chk("done_err", 32'(bus.cmd_err),  32'd0);
      if (code == OW_CMD_INIT) begin
         pres_m = pres;
         chk("presence", 32'(bus.presence), 32'(pres_m));
      end
      chk("rd_data",  32'(bus.rd_data),  32'(rd_m));
      chk("gnt_hold", 32'(bus.gnt),      32'(bit_of(k)));
      tick();
      chk("done_pulse", 32'(bus.cmd_done), 32'd0);
   endtask

   task automatic release_bus(input int k);
      bus.req = bus.req & ~bit_of(k);
      tick();
      chk("release_gnt", 32'(bus.gnt), 32'd0);
      last_m = k;
   endtask

   initial begin
      int          order [5];
      int          w;
      int          cnt;
      logic [N-1:0] rv;

      order = '{0, 1, 2, 3, 0};
      do_reset();

      // Init with presence, then a SKIP ROM write, from requester 0
      bus.req = 4'b0001;
      tick();
      chk("t1_gnt", 32'(bus.gnt), 32'(4'b0001));
      do_cmd(0, OW_CMD_INIT, 8'h00, 2, 1'b1, 16'h0000);
      do_cmd(0, OW_CMD_WRITE, OW_ROM_SKIP, 3, 1'b0, 16'h0000);
      release_bus(0);

      // Read from requester 2
      bus.req = 4'b0100;
      tick();
      chk("t3_gnt", 32'(bus.gnt), 32'(4'b0100));
      do_cmd(2, OW_CMD_READ, 8'h00, 2, 1'b0, 16'h0191);
      chk("t3_rd_0191", 32'(bus.rd_data), 32'h0191);
      release_bus(2);

      // All four request continuously: order 0,1,2,3,0 with an idle cycle between
      do_reset();
      bus.req = '1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_order", 32'(bus.gnt), 32'(bit_of(order[i])));
         do_cmd(order[i], OW_CMD_WRITE, 8'($urandom), 1, 1'b0, 16'h0000);
         release_bus(order[i]);
         if (i < 4) bus.req = bus.req | bit_of(order[i]);
         else       bus.req = '0;
      end

      // Owner 1 drops req mid-command; requester 3 strobes while not owner
      bus.req = 4'b0010;
      tick();
      chk("t5_gnt1", 32'(bus.gnt), 32'(4'b0010));
      bus.req = 4'b1010;
      set_field(3, OW_CMD_WRITE, OW_FN_WRITE_SCRATCH);
      bus.cmd_valid = 4'b1000;
      tick();
      bus.cmd_valid = '0;
      chk("t5_foreign_strobe", 32'(bus.ow_cmd), 32'd0);
      set_field(1, OW_CMD_WRITE, OW_FN_CONVERT);
      bus.cmd_valid = 4'b0010;
      tick();
      bus.cmd_valid = '0;
      chk("t5_ow_cmd", 32'(bus.ow_cmd),  32'(OW_CMD_WRITE));
      chk("t5_ow_data", 32'(bus.ow_data), 32'(OW_FN_CONVERT));
      bus.req = 4'b1000;
      tick();
      chk("t5_busy_gnt", 32'(bus.gnt), 32'(4'b0010));
      chk("t5_busy_done", 32'(bus.cmd_done), 32'd0);
      bus.ow_cmd_ok = 3'b010;
      tick();
      engine_idle();
      chk("t5_done", 32'(bus.cmd_done), 32'd1);
      chk("t5_release_with_done", 32'(bus.gnt), 32'd0);
      last_m = 1;
      tick();
      chk("t5_gnt3", 32'(bus.gnt), 32'(bit_of(pick(4'b1000, last_m))));
      chk("t5_no_stale_cmd", 32'(bus.ow_cmd), 32'd0);
      do_cmd(3, OW_CMD_NONE, 8'h00, 0, 1'b0, 16'h0000);
      release_bus(3);

      // Randomized transactions against the round-robin/scoreboard model
      for (int r = 0; r < 16; r++) begin
         rv      = N'($urandom_range(1, (1 << N) - 1));
         bus.req = rv;
         tick();
         w = pick(rv, last_m);
         chk("rand_gnt", 32'(bus.gnt), 32'(bit_of(w)));
         for (int j = 0; j < $urandom_range(1, 3); j++) begin
            do_cmd(w, 2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 4),
                   1'($urandom), 16'($urandom));
         end
         release_bus(w);
      end

`ifdef OW_ARB_WDT_EN
      // Silent engine: timeout TO cycles after the engine strobe; late answer ignored
      bus.req = 4'b0001;
      tick();
      w = pick(4'b0001, last_m);
      chk("wdt_gnt", 32'(bus.gnt), 32'(bit_of(w)));
      set_field(0, OW_CMD_WRITE, OW_ROM_MATCH);
      bus.cmd_valid = 4'b0001;
      tick();
      bus.cmd_valid = '0;
      chk("wdt_ow_cmd", 32'(bus.ow_cmd), 32'(OW_CMD_WRITE));
      cnt = 0;
      while (cnt < 3 * TO && bus.cmd_done !== 1'b1) begin
         tick();
         cnt++;
      end
      chk("wdt_latency", 32'(cnt), 32'(TO));
      chk("wdt_err",     32'(bus.cmd_err), 32'd1);
      chk("wdt_rd_keep", 32'(bus.rd_data), 32'(rd_m));
      tick();
      bus.ow_cmd_ok = 3'b010;
      tick();
      engine_idle();
      chk("wdt_late_ignored", 32'(bus.cmd_done), 32'd0);
      release_bus(0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
